// File: rtl/shift_register_param.sv
// shift_register_param: WIDTH-bit universal register with load, clear,
// logical/arithmetic shifts and rotates, serial in/out, and a shift-by-N
// sequencer with busy/done handshake.
// Optional build macro: SHIFT_REGISTER_BARREL_EN -- when defined, shift and
// rotate ops finish at the accepting edge through a combinational barrel
// shifter and the SHIFT state is never entered.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; HOLD/LOAD/CLR and zero-distance ops finish here
// S_SHIFT | one 1-bit shift/rotate per edge until r_count reaches zero
module shift_register_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_ASR  = 3'd5;
    localparam logic [2:0] OP_ROL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic               r_so;
    logic               r_done;
    logic [AMT_W-1:0]   r_count;
    logic [2:0]         r_op;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_so_nxt;
    logic               w_done_nxt;
    logic [AMT_W-1:0]   w_count_nxt;
    logic [2:0]         w_op_nxt;

    logic [AMT_W-1:0]   w_amt_sat;
    logic [WIDTH:0]     w_step;

    // One 1-bit step of a shift/rotate; result is {bit_leaving, new_q}.
    function automatic logic [WIDTH:0] f_step(input logic [2:0]       f_op,
                                              input logic [WIDTH-1:0] f_q,
                                              input logic             f_si);
        logic [WIDTH:0] res;
        res = {1'b0, f_q};
        case (f_op)
            OP_SHL:  res = {f_q[WIDTH-1], f_q[WIDTH-2:0], f_si};
            OP_SHR:  res = {f_q[0], f_si, f_q[WIDTH-1:1]};
            OP_ASR:  res = {f_q[0], f_q[WIDTH-1], f_q[WIDTH-1:1]};
            OP_ROL:  res = {f_q[WIDTH-1], f_q[WIDTH-2:0], f_q[WIDTH-1]};
            OP_ROR:  res = {f_q[0], f_q[0], f_q[WIDTH-1:1]};
            default: res = {1'b0, f_q};
        endcase
        return res;
    endfunction

    // Distances beyond WIDTH behave exactly like WIDTH.
    assign w_amt_sat = (amt > AMT_MAX) ? AMT_MAX : amt;
    assign w_step    = f_step(r_op, r_q, serial_in);

`ifdef SHIFT_REGISTER_BARREL_EN
    logic [WIDTH-1:0]   w_bar_q;
    logic               w_bar_so;

    // Full-distance shift/rotate in one step; the last bit to leave is the
    // one originally amt-1 positions from the exit end.
    always_comb begin
        logic [2*WIDTH-1:0] v_ext;
        logic [WIDTH-1:0]   v_tap;
        logic [AMT_W-1:0]   v_nm1;
        w_bar_q  = r_q;
        w_bar_so = r_so;
        v_ext    = '0;
        v_tap    = '0;
        v_nm1    = w_amt_sat - AMT_W'(1);
        case (op)
            OP_SHL: begin
                v_ext    = {r_q, {WIDTH{serial_in}}} << w_amt_sat;
                w_bar_q  = v_ext[2*WIDTH-1:WIDTH];
                v_tap    = r_q << v_nm1;
                w_bar_so = v_tap[WIDTH-1];
            end
            OP_SHR: begin
                v_ext    = {{WIDTH{serial_in}}, r_q} >> w_amt_sat;
                w_bar_q  = v_ext[WIDTH-1:0];
                v_tap    = r_q >> v_nm1;
                w_bar_so = v_tap[0];
            end
            OP_ASR: begin
                v_ext    = {{WIDTH{r_q[WIDTH-1]}}, r_q} >> w_amt_sat;
                w_bar_q  = v_ext[WIDTH-1:0];
                v_tap    = r_q >> v_nm1;
                w_bar_so = v_tap[0];
            end
            OP_ROL: begin
                v_ext    = {r_q, r_q} << w_amt_sat;
                w_bar_q  = v_ext[2*WIDTH-1:WIDTH];
                v_tap    = r_q << v_nm1;
                w_bar_so = v_tap[WIDTH-1];
            end
            OP_ROR: begin
                v_ext    = {r_q, r_q} >> w_amt_sat;
                w_bar_q  = v_ext[WIDTH-1:0];
                v_tap    = r_q >> v_nm1;
                w_bar_so = v_tap[0];
            end
            default: begin
                w_bar_q  = r_q;
                w_bar_so = r_so;
            end
        endcase
    end
`endif

    // Next-state and datapath decode for both states.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_so_nxt    = r_so;
        w_done_nxt  = 1'b0;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op < OP_SHL) begin
                        case (op)
                            OP_LOAD: w_q_nxt = d;
                            OP_CLR:  w_q_nxt = '0;
                            default: w_q_nxt = r_q;
                        endcase
                        w_done_nxt = 1'b1;
                    end else begin
`ifdef SHIFT_REGISTER_BARREL_EN
                        if (w_amt_sat != '0) begin
                            w_q_nxt  = w_bar_q;
                            w_so_nxt = w_bar_so;
                        end
                        w_done_nxt = 1'b1;
`else
                        w_op_nxt    = op;
                        w_count_nxt = w_amt_sat;
                        if (w_amt_sat == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_SHIFT;
                        end
`endif
                    end
                end
            end
            S_SHIFT: begin
                w_q_nxt     = w_step[WIDTH-1:0];
                w_so_nxt    = w_step[WIDTH];
                w_count_nxt = r_count - AMT_W'(1);
                if (r_count == AMT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_op    <= OP_HOLD;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_so    <= w_so_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign q          = r_q;
    assign serial_out = r_so;
    assign done       = r_done;
`ifdef SHIFT_REGISTER_BARREL_EN
    assign busy       = 1'b0;
`else
    assign busy       = (r_state == S_SHIFT);
`endif

endmodule

// File: tb/tb_shift_register_param.sv
// Self-checking bench for shift_register_param (WIDTH=8): directed vector
// table, hand-written multi-cycle sequences, then randomized ops against a
// behavioural model.
module tb_shift_register_param;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_ASR  = 3'd5;
    localparam logic [2:0] OP_ROL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

`ifdef SHIFT_REGISTER_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  d;
    logic          serial_in;
    logic [W-1:0]  q;
    logic          serial_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_q;
    logic         m_so;

    typedef struct {
        logic [2:0] op;
        int         amt;
        logic [7:0] d;
        logic       si;
        logic [7:0] exp_q;
        logic       exp_so;
        int         exp_busy;
    } vec_t;

    vec_t tbl [18];

    shift_register_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .amt        (amt),
        .d          (d),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Whole-operation model: result computed from the distance in one go.
    task automatic model(input logic [2:0] o, input int a, input logic [W-1:0] dd,
                         input logic si, output int nb);
        int qi, n, fill, sx;
        qi = int'(m_q);
        n  = (a > W) ? W : a;
        nb = 0;
        case (o)
            OP_LOAD: m_q = dd;
            OP_CLR:  m_q = '0;
            default: ;
        endcase
        if (o >= OP_SHL) begin
            nb = BARREL ? 0 : n;
            if (n > 0) begin
                fill = (1 << n) - 1;
                case (o)
                    OP_SHL: begin
                        m_q  = W'((qi << n) | (si ? fill : 0));
                        m_so = qi[W-n];
                    end
                    OP_SHR: begin
                        m_q  = W'((qi >> n) | (si ? (fill << (W - n)) : 0));
                        m_so = qi[n-1];
                    end
                    OP_ASR: begin
                        sx   = qi[W-1] ? qi - (1 << W) : qi;
                        m_q  = W'(sx >>> n);
                        m_so = qi[n-1];
                    end
                    OP_ROL: begin
                        m_q  = W'((qi << n) | (qi >> (W - n)));
                        m_so = qi[W-n];
                    end
                    default: begin
                        m_q  = W'((qi >> n) | (qi << (W - n)));
                        m_so = qi[n-1];
                    end
                endcase
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input int a,
                         input logic [W-1:0] dd, input logic si,
                         input logic [W-1:0] eq, input logic eso, input int enb);
        int waited, bc;
        op = o; amt = AW'(a); d = dd; serial_in = si; start = 1'b1;
        tick;
        start = 1'b0;
        op = OP_HOLD;
        waited = 0;
        bc = 0;
        while (!done && waited < 40) begin
            if (busy) bc++;
            tick;
            waited++;
        end
        chk({tag, " done_seen"}, done, 1);
        chk({tag, " latency"}, waited, enb);
        chk({tag, " busy_cycles"}, bc, enb);
        chk({tag, " q"}, q, eq);
        chk({tag, " serial_out"}, serial_out, eso);
        tick;
        chk({tag, " done_one_cycle"}, done, 0);
    endtask

    task automatic model_op(input string tag, input logic [2:0] o, input int a,
                            input logic [W-1:0] dd, input logic si);
        int nb;
        model(o, a, dd, si, nb);
        do_op(tag, o, a, dd, si, m_q, m_so, nb);
    endtask

    initial begin
        logic [7:0] steps [3];
        int w;

        tbl[0]  = '{OP_LOAD, 0, 8'hA5, 1'b0, 8'hA5, 1'b0, 0};
        tbl[1]  = '{OP_HOLD, 0, 8'hFF, 1'b0, 8'hA5, 1'b0, 0};
        tbl[2]  = '{OP_LOAD, 0, 8'h0B, 1'b0, 8'h0B, 1'b0, 0};
        tbl[3]  = '{OP_ROR,  3, 8'h00, 1'b0, 8'h61, 1'b0, 3};
        tbl[4]  = '{OP_LOAD, 0, 8'h90, 1'b0, 8'h90, 1'b0, 0};
        tbl[5]  = '{OP_ASR,  2, 8'h00, 1'b0, 8'hE4, 1'b0, 2};
        tbl[6]  = '{OP_LOAD, 0, 8'h81, 1'b0, 8'h81, 1'b0, 0};
        tbl[7]  = '{OP_SHL,  3, 8'h00, 1'b1, 8'h0F, 1'b0, 3};
        tbl[8]  = '{OP_LOAD, 0, 8'h3C, 1'b0, 8'h3C, 1'b0, 0};
        tbl[9]  = '{OP_ROL,  8, 8'h00, 1'b0, 8'h3C, 1'b0, 8};
        tbl[10] = '{OP_SHR,  0, 8'h00, 1'b1, 8'h3C, 1'b0, 0};
        tbl[11] = '{OP_LOAD, 0, 8'hA5, 1'b0, 8'hA5, 1'b0, 0};
        tbl[12] = '{OP_SHR,  9, 8'h00, 1'b1, 8'hFF, 1'b1, 8};
        tbl[13] = '{OP_SHL,  8, 8'h00, 1'b0, 8'h00, 1'b1, 8};
        tbl[14] = '{OP_LOAD, 0, 8'h80, 1'b0, 8'h80, 1'b1, 0};
        tbl[15] = '{OP_ROL,  1, 8'h00, 1'b0, 8'h01, 1'b1, 1};
        tbl[16] = '{OP_ROR, 15, 8'h00, 1'b0, 8'h01, 1'b0, 8};
        tbl[17] = '{OP_CLR,  0, 8'h00, 1'b0, 8'h00, 1'b0, 0};

        reset = 1'b1; start = 1'b0; op = OP_HOLD; amt = '0; d = '0; serial_in = 1'b0;
        #12;
        chk("reset q", q, 0);
        chk("reset serial_out", serial_out, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 18; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].amt, tbl[i].d, tbl[i].si,
                  tbl[i].exp_q, tbl[i].exp_so, (BARREL && tbl[i].op >= OP_SHL) ? 0 : tbl[i].exp_busy);
        end
        m_q = 8'h00;
        m_so = 1'b0;

        // Stepwise ROR by 3 on 0x0B.
        model_op("ror_prep", OP_LOAD, 0, 8'h0B, 1'b0);
        steps[0] = 8'h85; steps[1] = 8'hC2; steps[2] = 8'h61;
        op = OP_ROR; amt = AW'(3); start = 1'b1;
        tick;
        start = 1'b0;
`ifdef SHIFT_REGISTER_BARREL_EN
        chk("ror_step q_at_accept", q, 8'h61);
        chk("ror_step busy", busy, 0);
        chk("ror_step done", done, 1);
`else
        chk("ror_step q_at_accept", q, 8'h0B);
        chk("ror_step busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("ror_step q%0d", i), q, steps[i]);
        end
        chk("ror_step done", done, 1);
        chk("ror_step busy_end", busy, 0);
`endif
        chk("ror_step serial_out", serial_out, 0);
        tick;
        chk("ror_step done_low", done, 0);

        // Start while busy is ignored; start coinciding with done is accepted.
        model_op("busy_prep", OP_LOAD, 0, 8'h0B, 1'b0);
        op = OP_ROR; amt = AW'(3); start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        op = OP_LOAD; d = 8'hFF; amt = '0; start = 1'b1;
        tick;
        start = 1'b0; op = OP_HOLD; d = 8'h00;
        w = 0;
        while (!done && w < 40) begin
            tick;
            w++;
        end
        chk("busy_start done_seen", done, 1);
        chk("busy_start q", q, BARREL ? 8'hFF : 8'h61);
        op = OP_LOAD; d = 8'h12; start = 1'b1;
        tick;
        start = 1'b0; op = OP_HOLD;
        chk("done_start q", q, 8'h12);
        chk("done_start done", done, 1);
        tick;
        m_q = 8'h12;

        // Asynchronous reset in the middle of a ROL by 5.
        model_op("rst_prep", OP_LOAD, 0, 8'hC0, 1'b0);
        op = OP_ROL; amt = AW'(5); start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
`ifndef SHIFT_REGISTER_BARREL_EN
        chk("rst_mid busy_before", busy, 1);
        chk("rst_mid so_before", serial_out, 1);
`endif
        reset = 1'b1;
        #1;
        chk("rst_mid q", q, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid done", done, 0);
        chk("rst_mid serial_out", serial_out, 0);
        @(negedge clk);
        reset = 1'b0;
        tick;
        m_q = '0;
        m_so = 1'b0;

        for (int i = 0; i < 150; i++) begin
            logic [2:0] ro;
            int ra;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
            model_op($sformatf("rnd%0d", i), ro, ra, W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
- WIDTH-bit universal register: the parametrised successor to the fixed-width D-register built from per-bit flip-flops.
- Adds load, clear, logical/arithmetic shift and rotate operations, a multi-cycle shift-by-N sequencer with busy/done handshake, and serial in/out.
- Used as the datapath shift/hold element feeding ALU and serial-link blocks.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input (must be able to encode WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  3  0 HOLD, 1 LOAD, 2 CLR, 3 SHL, 4 SHR, 5 ASR, 6 ROL, 7 ROR.
- amt  input  AMT_W  shift/rotate distance; latched at the accepting edge.
- d  input  WIDTH  parallel load data.
- serial_in  input  1  fill bit for SHL/SHR; sampled on every shift edge.
- q  output  WIDTH  register contents.
- serial_out  output  1  last bit shifted or rotated out (registered).
- busy  output  1  high while the SHIFT state is active.
- done  output  1  one-cycle completion pulse.

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset (asynchronous, at any time, including mid-shift):
  - q=0, serial_out=0, busy=0, done=0, state=IDLE, count=0.
  - Any pending operation is abandoned.
- States: IDLE and SHIFT.
- IDLE, start=0: q holds; done=0.
- IDLE, start=1, op HOLD/LOAD/CLR:
  - At that edge: HOLD keeps q, LOAD sets q=d, CLR sets q=0.
  - done=1 for the next cycle; busy stays 0; state stays IDLE.
- IDLE, start=1, op SHL..ROR:
  - The edge latches op and count=min(amt,WIDTH).
  - If count=0: no change to q, done pulses next cycle, no SHIFT entry.
  - Otherwise go to SHIFT with busy=1. q is unchanged at the accepting edge.
- SHIFT: each edge performs one 1-bit operation and decrements count.
  - SHL: q={q[W-2:0],serial_in}; serial_out=q[W-1].
  - SHR: q={serial_in,q[W-1:1]}; serial_out=q[0].
  - ASR: q={q[W-1],q[W-1:1]}; serial_out=q[0].
  - ROL: q={q[W-2:0],q[W-1]}; serial_out=q[W-1].
  - ROR: q={q[0],q[W-1:1]}; serial_out=q[0].
  - The edge performing the last shift sets state=IDLE, busy=0, done=1 (single cycle).
- Latency: a shift by N has busy high for N cycles; done is seen N+1 cycles after the accepting edge.
- start while busy is ignored. op, amt and d changes while busy have no effect.
- done and start may coincide: a new start sampled in the cycle done is high is accepted, since the state is IDLE.
- serial_out changes only on shift edges. It holds through LOAD/CLR/HOLD.
- Rotate by WIDTH restores the original q. SHL/SHR by WIDTH leave q filled with the sampled serial_in bits.

Optional Feature:
- Macro: SHIFT_REGISTER_BARREL_EN.
- Defined:
  - Shift/rotate ops complete at the accepting edge via a combinational barrel shifter; SHIFT state and busy are never entered (busy is tied 0).
  - done pulses next cycle.
  - Vacated bits for SHL/SHR are all serial_in (sampled once at that edge).
  - serial_out = last bit leaving, i.e. the bit originally at distance amt-1 from the exit end; it is unchanged when amt=0.
  - Final q and serial_out equal the iterative result for a constant serial_in.
- Undefined: iterative 1-bit-per-cycle behaviour as above.

Test Plan (WIDTH=8, macro undefined unless stated):
- Reset mid-SHIFT (ROL amt=5, reset after 2 shift edges) -> q=0x00, busy=0, done=0, serial_out=0 immediately, without waiting for a clock.
- LOAD d=0xA5, then HOLD -> q=0xA5 after the accepting edge, done pulses 1 cycle each, busy never 1.
- ROR amt=3 on q=0x0B -> q steps 0x85, 0xC2, 0x61; busy 3 cycles; done next cycle; serial_out=0.
- ASR amt=2 on 0x90 -> 0xC8 then 0xE4, serial_out=0; SHL amt=3 on 0x81 with serial_in=1 -> 0x03, 0x07, 0x0F, serial_out=0.
- start pulsed while busy (LOAD d=0xFF) -> ignored, shift result unaffected; ROL amt=8 on 0x3C -> q=0x3C; amt=0 -> done next cycle, q unchanged.
- Macro defined: ROR amt=3 on 0x0B -> q=0x61 at the accepting edge, busy stays 0, done pulses next cycle, serial_out=0.
